rs_alu: RTL and testbench

//  Reservation station feeding the combinational ALU exec unit: the consumer end of the CDB.

---
 rtl/rs_alu_pkg.sv | 59 +++++
 rtl/rs_alu_pick.sv | 31 +++
 rtl/rs_alu.sv | 142 ++++++++++++++
 tb/tb_rs_alu.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_pkg.sv
// ============================================================================
// Module      : rs_alu_pkg
// Description : Shared sizes, opcode codes, entry layout and a CDB-capture
//               helper for the ALU reservation station.
// Contents    : RS_SIZE/IDX_W/TAG_W/OPT_W, OPT_* codes, entry_t, cdb_capture()
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_alu_pkg;

  localparam int RS_SIZE = 8;
  localparam int IDX_W   = 3;
  localparam int TAG_W   = 4;
  localparam int OPT_W   = 6;

  localparam logic [OPT_W-1:0] OPT_ADD = 6'd1;
  localparam logic [OPT_W-1:0] OPT_SUB = 6'd2;
  localparam logic [OPT_W-1:0] OPT_AND = 6'd3;
  localparam logic [OPT_W-1:0] OPT_OR  = 6'd4;
  localparam logic [OPT_W-1:0] OPT_XOR = 6'd5;

  typedef struct packed {
    logic [OPT_W-1:0] opt;
    logic [31:0]      vj;
    logic [TAG_W-1:0] qj;
    logic             qj_busy;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qk;
    logic             qk_busy;
    logic [31:0]      imm;
    logic [TAG_W-1:0] dest;
  } entry_t;

  // Returns {still_pending, value}. The ALU CDB is tested first so it wins
  // when both buses carry the same tag.
  function automatic logic [32:0] cdb_capture(
    input logic             pend,
    input logic [TAG_W-1:0] tag,
    input logic [31:0]      val,
    input logic             alu_ok,
    input logic [TAG_W-1:0] alu_en,
    input logic [31:0]      alu_val,
    input logic             lsb_ok,
    input logic [TAG_W-1:0] lsb_en,
    input logic [31:0]      lsb_val
  );
    logic [32:0] res;
    res = {pend, val};
    if (pend) begin
      if (alu_ok && (alu_en == tag))      res = {1'b0, alu_val};
      else if (lsb_ok && (lsb_en == tag)) res = {1'b0, lsb_val};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_alu_pick.sv
// ============================================================================
// Module      : rs_pick
// Description : Lowest-set-bit priority encoder.
// Ports       : req   in  N  request vector
//               idx   out W  index of lowest set bit (0 when none)
//               found out 1  any bit set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the lowest set bit is the last write.
  always_comb begin
    idx   = '0;
    found = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rs_alu.sv
// ============================================================================
// Module      : rs_alu
// Description : Reservation station for the combinational ALU exec unit.
//               Holds issued ops, snoops the ALU and LSB CDBs for pending
//               operand tags and dispatches one ready op per cycle on
//               registered ex_* outputs.
// Ports       : clk_in, rst_n (sync, active low), rdy_in (hold), flush_in
//               iss_*     issue request and operands / tags
//               rs_full   all entries busy (combinational)
//               cdb_alu_* / cdb_lsb_*  result broadcast buses
//               ex_*      registered dispatch to exec
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_alu
  import rs_alu_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             iss_valid,
  input  logic [OPT_W-1:0] iss_opt,
  input  logic             iss_qj_busy,
  input  logic [TAG_W-1:0] iss_qj,
  input  logic [31:0]      iss_vj,
  input  logic             iss_qk_busy,
  input  logic [TAG_W-1:0] iss_qk,
  input  logic [31:0]      iss_vk,
  input  logic [31:0]      iss_imm,
  input  logic [TAG_W-1:0] iss_dest,
  output logic             rs_full,
  input  logic             cdb_alu_ok,
  input  logic [TAG_W-1:0] cdb_alu_en,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_lsb_ok,
  input  logic [TAG_W-1:0] cdb_lsb_en,
  input  logic [31:0]      cdb_lsb_val,
  output logic             ex_ok,
  output logic [OPT_W-1:0] ex_opt,
  output logic [31:0]      ex_rs1,
  output logic [31:0]      ex_rs2,
  output logic [31:0]      ex_imm,
  output logic [TAG_W-1:0] ex_en
);

  entry_t             ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;
  logic               free_found;
  logic               rdy_found;
  entry_t             iss_ent;

  // Readiness is taken from registered state only, so a wakeup at edge N
  // can dispatch no earlier than edge N+1.
  for (genvar i = 0; i < RS_SIZE; i++) begin : g_ready
    assign ready[i] = busy[i] & ~ent[i].qj_busy & ~ent[i].qk_busy;
  end

  assign free    = ~busy;
  assign rs_full = &busy;

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_free_pick (
    .req   (free),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_ready_pick (
    .req   (ready),
    .idx   (rdy_idx),
    .found (rdy_found)
  );

  // New entry, with operands captured from a same-cycle CDB broadcast.
  always_comb begin
    iss_ent      = '0;
    iss_ent.opt  = iss_opt;
    iss_ent.qj   = iss_qj;
    iss_ent.qk   = iss_qk;
    iss_ent.imm  = iss_imm;
    iss_ent.dest = iss_dest;
    {iss_ent.qj_busy, iss_ent.vj} = cdb_capture(iss_qj_busy, iss_qj, iss_vj,
        cdb_alu_ok, cdb_alu_en, cdb_alu_val, cdb_lsb_ok, cdb_lsb_en, cdb_lsb_val);
    {iss_ent.qk_busy, iss_ent.vk} = cdb_capture(iss_qk_busy, iss_qk, iss_vk,
        cdb_alu_ok, cdb_alu_en, cdb_alu_val, cdb_lsb_ok, cdb_lsb_en, cdb_lsb_val);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      busy   <= '0;
      ex_ok  <= 1'b0;
      ex_opt <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_imm <= '0;
      ex_en  <= '0;
    end else if (flush_in) begin
      busy  <= '0;
      ex_ok <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          {ent[i].qj_busy, ent[i].vj} <= cdb_capture(ent[i].qj_busy, ent[i].qj, ent[i].vj,
              cdb_alu_ok, cdb_alu_en, cdb_alu_val, cdb_lsb_ok, cdb_lsb_en, cdb_lsb_val);
          {ent[i].qk_busy, ent[i].vk} <= cdb_capture(ent[i].qk_busy, ent[i].qk, ent[i].vk,
              cdb_alu_ok, cdb_alu_en, cdb_alu_val, cdb_lsb_ok, cdb_lsb_en, cdb_lsb_val);
        end
      end

      if (rdy_found) begin
        ex_ok         <= 1'b1;
        ex_opt        <= ent[rdy_idx].opt;
        ex_rs1        <= ent[rdy_idx].vj;
        ex_rs2        <= ent[rdy_idx].vk;
        ex_imm        <= ent[rdy_idx].imm;
        ex_en         <= ent[rdy_idx].dest;
        busy[rdy_idx] <= 1'b0;
      end else begin
        ex_ok <= 1'b0;
      end

      // free_idx comes from pre-edge busy, so it never equals rdy_idx.
      if (iss_valid && free_found) begin
        ent[free_idx]  <= iss_ent;
        busy[free_idx] <= 1'b1;
      end
    end else begin
      ex_ok <= 1'b0;
    end
  end

  a_no_issue_when_full : assert property (@(posedge clk_in) disable iff (!rst_n)
      (rdy_in && !flush_in) |-> !(iss_valid && rs_full));

endmodule

`default_nettype wire

// File: tb/tb_rs_alu.sv
// ============================================================================
// Module      : tb_rs_alu
// Description : Self-checking bench for rs_alu: behavioural station model
//               compared every cycle plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_alu;
  import rs_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
  logic        iss_valid = 1'b0, iss_qj_busy = 1'b0, iss_qk_busy = 1'b0;
  logic [5:0]  iss_opt = '0;
  logic [3:0]  iss_qj = '0, iss_qk = '0, iss_dest = '0;
  logic [31:0] iss_vj = '0, iss_vk = '0, iss_imm = '0;
  logic        cdb_alu_ok = 1'b0, cdb_lsb_ok = 1'b0;
  logic [3:0]  cdb_alu_en = '0, cdb_lsb_en = '0;
  logic [31:0] cdb_alu_val = '0, cdb_lsb_val = '0;
  logic        rs_full, ex_ok;
  logic [5:0]  ex_opt;
  logic [31:0] ex_rs1, ex_rs2, ex_imm;
  logic [3:0]  ex_en;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rs_alu dut (
    .clk_in(clk), .rst_n(rst_n), .rdy_in(rdy), .flush_in(flush),
    .iss_valid(iss_valid), .iss_opt(iss_opt),
    .iss_qj_busy(iss_qj_busy), .iss_qj(iss_qj), .iss_vj(iss_vj),
    .iss_qk_busy(iss_qk_busy), .iss_qk(iss_qk), .iss_vk(iss_vk),
    .iss_imm(iss_imm), .iss_dest(iss_dest), .rs_full(rs_full),
    .cdb_alu_ok(cdb_alu_ok), .cdb_alu_en(cdb_alu_en), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_ok(cdb_lsb_ok), .cdb_lsb_en(cdb_lsb_en), .cdb_lsb_val(cdb_lsb_val),
    .ex_ok(ex_ok), .ex_opt(ex_opt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_imm(ex_imm), .ex_en(ex_en)
  );

  // Model: each slot is either empty or holds an op whose operands are
  // known values or outstanding tags.
  typedef struct {
    bit          used;
    logic [5:0]  opt;
    bit          wait_j, wait_k;
    logic [3:0]  tag_j, tag_k, dest;
    logic [31:0] a, b, imm;
  } slot_t;

  slot_t       slots [8];
  bit          m_ok;
  logic [5:0]  m_opt;
  logic [31:0] m_rs1, m_rs2, m_imm;
  logic [3:0]  m_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A value on either bus satisfies a waiting operand; ALU bus first.
  task automatic resolve(inout bit w, input logic [3:0] t, inout logic [31:0] v);
    if (w && cdb_alu_ok && cdb_alu_en == t) begin w = 0; v = cdb_alu_val; end
    else if (w && cdb_lsb_ok && cdb_lsb_en == t) begin w = 0; v = cdb_lsb_val; end
  endtask

  task automatic model_step();
    int pick, slot;
    bit was_used [8];
    if (!rst_n) begin
      foreach (slots[i]) slots[i].used = 0;
      m_ok = 0; m_opt = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_en = 0;
      return;
    end
    if (flush) begin
      foreach (slots[i]) slots[i].used = 0;
      m_ok = 0;
      return;
    end
    if (!rdy) begin
      m_ok = 0;
      return;
    end
    foreach (slots[i]) was_used[i] = slots[i].used;
    pick = -1;
    for (int i = 7; i >= 0; i--)
      if (slots[i].used && !slots[i].wait_j && !slots[i].wait_k) pick = i;
    foreach (slots[i]) if (slots[i].used) begin
      resolve(slots[i].wait_j, slots[i].tag_j, slots[i].a);
      resolve(slots[i].wait_k, slots[i].tag_k, slots[i].b);
    end
    m_ok = (pick >= 0);
    if (pick >= 0) begin
      m_opt = slots[pick].opt; m_rs1 = slots[pick].a; m_rs2 = slots[pick].b;
      m_imm = slots[pick].imm; m_en = slots[pick].dest;
      slots[pick].used = 0;
    end
    slot = -1;
    for (int i = 7; i >= 0; i--) if (!was_used[i]) slot = i;
    if (iss_valid && slot >= 0) begin
      slots[slot].used = 1; slots[slot].opt = iss_opt; slots[slot].imm = iss_imm;
      slots[slot].dest = iss_dest;
      slots[slot].wait_j = iss_qj_busy; slots[slot].tag_j = iss_qj; slots[slot].a = iss_vj;
      slots[slot].wait_k = iss_qk_busy; slots[slot].tag_k = iss_qk; slots[slot].b = iss_vk;
      resolve(slots[slot].wait_j, slots[slot].tag_j, slots[slot].a);
      resolve(slots[slot].wait_k, slots[slot].tag_k, slots[slot].b);
    end
  endtask

  function automatic bit model_full();
    foreach (slots[i]) if (!slots[i].used) return 0;
    return 1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_ok", {31'd0, ex_ok}, {31'd0, m_ok});
      check("ex_opt", {26'd0, ex_opt}, {26'd0, m_opt});
      check("ex_rs1", ex_rs1, m_rs1);
      check("ex_rs2", ex_rs2, m_rs2);
      check("ex_imm", ex_imm, m_imm);
      check("ex_en", {28'd0, ex_en}, {28'd0, m_en});
      check("rs_full", {31'd0, rs_full}, {31'd0, model_full()});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_in();
    iss_valid = 0; iss_qj_busy = 0; iss_qk_busy = 0;
    cdb_alu_ok = 0; cdb_lsb_ok = 0; flush = 0;
  endtask

  task automatic issue(input logic [5:0] opt, input bit pj, input logic [3:0] qj,
                       input logic [31:0] vj, input bit pk, input logic [3:0] qk,
                       input logic [31:0] vk, input logic [31:0] imm, input logic [3:0] dest);
    iss_valid = 1; iss_opt = opt; iss_qj_busy = pj; iss_qj = qj; iss_vj = vj;
    iss_qk_busy = pk; iss_qk = qk; iss_vk = vk; iss_imm = imm; iss_dest = dest;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst_n = 0;
    tick(); tick();
    chk_en = 1;
    check("reset ex_ok", {31'd0, ex_ok}, 32'd0);
    check("reset rs_full", {31'd0, rs_full}, 32'd0);
    rst_n = 1;
    tick();

    // 1: both operands ready -> dispatch one edge after issue
    issue(OPT_ADD, 0, 0, 32'd5, 0, 0, 32'd7, 32'd0, 4'd3);
    tick(); clear_in();
    check("t1 no early dispatch", {31'd0, ex_ok}, 32'd0);
    tick();
    check("t1 ex_ok", {31'd0, ex_ok}, 32'd1);
    check("t1 ex_opt", {26'd0, ex_opt}, {26'd0, OPT_ADD});
    check("t1 ex_rs1", ex_rs1, 32'd5);
    check("t1 ex_rs2", ex_rs2, 32'd7);
    check("t1 ex_en", {28'd0, ex_en}, 32'd3);
    check("t1 exec sum", ex_rs1 + ex_rs2, 32'd12);
    tick();
    check("t1 single dispatch", {31'd0, ex_ok}, 32'd0);

    // 2: rs1 waits on tag 2, woken by LSB CDB
    issue(OPT_SUB, 1, 4'd2, 32'd0, 0, 0, 32'd1, 32'd0, 4'd5);
    tick(); clear_in(); tick();
    check("t2 waiting", {31'd0, ex_ok}, 32'd0);
    cdb_lsb_ok = 1; cdb_lsb_en = 4'd2; cdb_lsb_val = 32'd10;
    tick(); clear_in();
    check("t2 wake edge", {31'd0, ex_ok}, 32'd0);
    tick();
    check("t2 ex_ok", {31'd0, ex_ok}, 32'd1);
    check("t2 ex_rs1", ex_rs1, 32'd10);
    check("t2 ex_rs2", ex_rs2, 32'd1);
    check("t2 ex_en", {28'd0, ex_en}, 32'd5);
    tick();

    // 3: issue bypass from same-cycle ALU CDB
    issue(OPT_ADD, 0, 0, 32'd1, 1, 4'd4, 32'd0, 32'd0, 4'd7);
    cdb_alu_ok = 1; cdb_alu_en = 4'd4; cdb_alu_val = 32'd9;
    tick(); clear_in();
    check("t3 issue edge", {31'd0, ex_ok}, 32'd0);
    tick();
    check("t3 ex_ok", {31'd0, ex_ok}, 32'd1);
    check("t3 ex_rs2", ex_rs2, 32'd9);
    tick();

    // 4: fill all 8 on tag 6, then release them in index order
    for (int i = 0; i < 8; i++) begin
      issue(OPT_XOR, 1, 4'd6, 32'd0, 0, 0, 32'(i), 32'(i * 3), 4'(8 + i));
      tick();
    end
    clear_in();
    check("t4 full", {31'd0, rs_full}, 32'd1);
    cdb_alu_ok = 1; cdb_alu_en = 4'd6; cdb_alu_val = 32'h1234;
    tick(); clear_in();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4 ex_ok", {31'd0, ex_ok}, 32'd1);
      check("t4 order", {28'd0, ex_en}, 32'(8 + i));
      if (i == 0) check("t4 full drops", {31'd0, rs_full}, 32'd0);
    end
    check("t4 rs1", ex_rs1, 32'h1234);
    tick();

    // 5: flush drops stored entries and a same-cycle issue
    for (int i = 0; i < 3; i++) begin
      issue(OPT_AND, 1, 4'd1, 32'd0, 0, 0, 32'd2, 32'd0, 4'(i));
      tick();
    end
    issue(OPT_OR, 0, 0, 32'd3, 0, 0, 32'd4, 32'd0, 4'd2);
    flush = 1;
    tick(); clear_in();
    check("t5 ex_ok", {31'd0, ex_ok}, 32'd0);
    check("t5 rs_full", {31'd0, rs_full}, 32'd0);
    cdb_lsb_ok = 1; cdb_lsb_en = 4'd1; cdb_lsb_val = 32'd77;
    tick(); clear_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5 never dispatch", {31'd0, ex_ok}, 32'd0);
    end

    // 6: rdy low holds state and ignores the CDB
    issue(OPT_ADD, 0, 0, 32'd8, 1, 4'd9, 32'd0, 32'd0, 4'd6);
    tick();
    issue(OPT_ADD, 0, 0, 32'd2, 0, 0, 32'd3, 32'd0, 4'd4);
    tick(); clear_in();
    rdy = 0;
    cdb_alu_ok = 1; cdb_alu_en = 4'd9; cdb_alu_val = 32'd100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6 held", {31'd0, ex_ok}, 32'd0);
    end
    clear_in(); rdy = 1;
    tick();
    check("t6 resume ok", {31'd0, ex_ok}, 32'd1);
    check("t6 resume en", {28'd0, ex_en}, 32'd4);
    tick();
    check("t6 no capture", {31'd0, ex_ok}, 32'd0);
    cdb_alu_ok = 1; cdb_alu_en = 4'd9; cdb_alu_val = 32'd50;
    tick(); clear_in();
    tick();
    check("t6 late ok", {31'd0, ex_ok}, 32'd1);
    check("t6 late rs2", ex_rs2, 32'd50);
    check("t6 late en", {28'd0, ex_en}, 32'd6);
    tick(); tick();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
